// File: rtl/layer_sequencer.sv
// Purpose : walks one inference frame through every network layer, one engine step at a time.
// Latency : step_start one cycle after any state/index change; next change on an accepted step_done.
// Backpressure: holds the current step until the engine returns step_done; abort drops the frame to IDLE.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start, abort, step_done         frame start (IDLE only), frame abandon, engine step completion
//   state, current_loop,            current layer code and step indices
//   current_filter, Pool_loop
//   step_start, busy, frame_done    step request pulse, frame in flight, frame completion pulse
module layer_sequencer #(
    parameter int C11_F = 6,
    parameter int C11_L = 1,
    parameter int C12_F = 6,
    parameter int C12_L = 2,
    parameter int C21_F = 16,
    parameter int C21_L = 2,
    parameter int C22_F = 16,
    parameter int C22_L = 4,
    parameter int C31_F = 16,
    parameter int C31_L = 4,
    parameter int C32_F = 16,
    parameter int C32_L = 4,
    parameter int P1_L  = 2,
    parameter int P2_L  = 4,
    parameter int P3_L  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       step_done,
    output logic [3:0] state,
    output logic [1:0] current_loop,
    output logic [3:0] current_filter,
    output logic [1:0] Pool_loop,
    output logic       step_start,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_IDLE    = 4'd1,
        S_CONV1_1 = 4'd2,
        S_CONV1_2 = 4'd3,
        S_POOL1   = 4'd4,
        S_CONV2_1 = 4'd5,
        S_CONV2_2 = 4'd6,
        S_POOL2   = 4'd7,
        S_CONV3_1 = 4'd8,
        S_CONV3_2 = 4'd9,
        S_POOL3   = 4'd10,
        S_FC      = 4'd11,
        S_JUDGE   = 4'd12
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] loop_q, loop_d;
    logic [3:0] filter_q, filter_d;
    logic [1:0] pool_q, pool_d;
    logic       step_start_q, step_start_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;
    // pending: indices just changed, step_start goes out next edge (step_done ignored here).
    // waiting: step_start already issued, engine still working.
    logic       pending_q, pending_d;
    logic       waiting_q, waiting_d;

    logic [3:0] last_f;
    logic [1:0] last_l;
    logic [1:0] last_p;
    logic       is_conv;
    logic       is_pool;
    logic       accept;

    // Per-layer step limits.
    always_comb begin
        last_f  = '0;
        last_l  = '0;
        last_p  = '0;
        is_conv = 1'b0;
        is_pool = 1'b0;
        case (state_q)
            S_CONV1_1: begin is_conv = 1'b1; last_f = 4'(C11_F - 1); last_l = 2'(C11_L - 1); end
            S_CONV1_2: begin is_conv = 1'b1; last_f = 4'(C12_F - 1); last_l = 2'(C12_L - 1); end
            S_CONV2_1: begin is_conv = 1'b1; last_f = 4'(C21_F - 1); last_l = 2'(C21_L - 1); end
            S_CONV2_2: begin is_conv = 1'b1; last_f = 4'(C22_F - 1); last_l = 2'(C22_L - 1); end
            S_CONV3_1: begin is_conv = 1'b1; last_f = 4'(C31_F - 1); last_l = 2'(C31_L - 1); end
            S_CONV3_2: begin is_conv = 1'b1; last_f = 4'(C32_F - 1); last_l = 2'(C32_L - 1); end
            S_POOL1:   begin is_pool = 1'b1; last_p = 2'(P1_L - 1); end
            S_POOL2:   begin is_pool = 1'b1; last_p = 2'(P2_L - 1); end
            S_POOL3:   begin is_pool = 1'b1; last_p = 2'(P3_L - 1); end
            default:   ;
        endcase
    end

    assign accept = step_done && (step_start_q || waiting_q);

    always_comb begin
        state_d      = state_q;
        loop_d       = loop_q;
        filter_d     = filter_q;
        pool_d       = pool_q;
        pending_d    = 1'b0;
        step_start_d = pending_q;
        waiting_d    = waiting_q || step_start_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_RESET: state_d = S_IDLE;
            S_IDLE: begin
                waiting_d = 1'b0;
                if (start) begin
                    state_d   = S_CONV1_1;
                    loop_d    = '0;
                    filter_d  = '0;
                    pool_d    = '0;
                    pending_d = 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    waiting_d    = 1'b0;
                    step_start_d = 1'b0;
                    if (state_q == S_JUDGE) begin
                        state_d      = S_IDLE;
                        frame_done_d = 1'b1;
                    end else if (is_conv && filter_q != last_f) begin
                        filter_d  = filter_q + 4'd1;
                        pending_d = 1'b1;
                    end else if (is_conv && loop_q != last_l) begin
                        filter_d  = '0;
                        loop_d    = loop_q + 2'd1;
                        pending_d = 1'b1;
                    end else if (is_pool && pool_q != last_p) begin
                        pool_d    = pool_q + 2'd1;
                        pending_d = 1'b1;
                    end else begin
                        // Layer codes are consecutive from CONV1_1 through JUDGE.
                        state_d   = state_t'(state_q + 4'd1);
                        loop_d    = '0;
                        filter_d  = '0;
                        pool_d    = '0;
                        pending_d = 1'b1;
                    end
                end
            end
        endcase

        // Abort overrides any step_done or start in the same cycle.
        if (abort && state_q != S_RESET) begin
            state_d      = S_IDLE;
            loop_d       = '0;
            filter_d     = '0;
            pool_d       = '0;
            pending_d    = 1'b0;
            step_start_d = 1'b0;
            waiting_d    = 1'b0;
            frame_done_d = 1'b0;
        end

        busy_d = (state_d != S_RESET) && (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RESET;
            loop_q       <= '0;
            filter_q     <= '0;
            pool_q       <= '0;
            step_start_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
            waiting_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            loop_q       <= loop_d;
            filter_q     <= filter_d;
            pool_q       <= pool_d;
            step_start_q <= step_start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            pending_q    <= pending_d;
            waiting_q    <= waiting_d;
        end
    end

    assign state          = state_q;
    assign current_loop   = loop_q;
    assign current_filter = filter_q;
    assign Pool_loop      = pool_q;
    assign step_start     = step_start_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: engine model answering step_start with step_done after a
// fixed or random delay; each issued step is compared against an expected step list
// built from the layer table (state, loop, filter, pool).
module tb_layer_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       step_done = 1'b0;
    logic [3:0] state;
    logic [1:0] current_loop;
    logic [3:0] current_filter;
    logic [1:0] Pool_loop;
    logic       step_start;
    logic       busy;
    logic       frame_done;

    layer_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .step_done      (step_done),
        .state          (state),
        .current_loop   (current_loop),
        .current_filter (current_filter),
        .Pool_loop      (Pool_loop),
        .step_start     (step_start),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Layer table with default parameters
    int conv_f[6] = '{6, 6, 16, 16, 16, 16};
    int conv_l[6] = '{1, 2, 2, 4, 4, 4};
    int pool_p[3] = '{2, 4, 4};

    int exp_q[$];

    function automatic int pack(input int st, input int l, input int f, input int p);
        return (st << 8) | (l << 6) | (f << 2) | p;
    endfunction

    // Every step of one frame, in issue order.
    task automatic build_frame();
        for (int g = 0; g < 3; g++) begin
            for (int c = 0; c < 2; c++)
                for (int l = 0; l < conv_l[2*g+c]; l++)
                    for (int f = 0; f < conv_f[2*g+c]; f++)
                        exp_q.push_back(pack(2 + 3*g + c, l, f, 0));
            for (int p = 0; p < pool_p[g]; p++)
                exp_q.push_back(pack(4 + 3*g, 0, 0, p));
        end
        exp_q.push_back(pack(11, 0, 0, 0));
        exp_q.push_back(pack(12, 0, 0, 0));
    endtask

    // Engine model state
    bit eng_en = 0;
    bit eng_rnd = 0;
    int eng_delay = 1;
    int eng_cnt = -1;
    int n_starts = 0;
    int fd_cnt = 0;
    bit abort_arm = 0;
    bit abort_hit = 0;

    task automatic cycle();
        int obs;
        @(negedge clk);
        step_done = 1'b0;
        abort = 1'b0;
        if (frame_done) fd_cnt++;
        if (eng_en) begin
            if (step_start) begin
                n_starts++;
                obs = pack(int'(state), int'(current_loop), int'(current_filter), int'(Pool_loop));
                if (exp_q.size() == 0) chk("extra_step_start", 1, 0);
                else chk("step_tuple", obs, exp_q.pop_front());
                eng_cnt = eng_rnd ? int'($urandom_range(0, 4)) : eng_delay;
            end
            if (eng_cnt == 0) begin
                step_done = 1'b1;
                eng_cnt = -1;
                if (abort_arm && state == 4'd8 && current_loop == 2'd2 && current_filter == 4'd7) begin
                    abort = 1'b1;
                    abort_hit = 1;
                    abort_arm = 0;
                end
            end else if (eng_cnt > 0) begin
                eng_cnt--;
            end
        end
    endtask

    task automatic run_frame(input string tag, input int budget);
        int fd0;
        int i;
        fd0 = fd_cnt;
        n_starts = 0;
        i = 0;
        while (fd_cnt == fd0 && i < budget) begin
            cycle();
            i++;
        end
        chk({tag, "_frame_done_cnt"}, fd_cnt - fd0, 1);
        chk({tag, "_steps"}, n_starts, 254);
        chk({tag, "_leftover"}, exp_q.size(), 0);
        chk({tag, "_end_state"}, int'(state), 1);
        chk({tag, "_end_busy"}, int'(busy), 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        int i;
        // Reset
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", int'(state), 0);
        chk("rst_idx", int'({current_loop, current_filter, Pool_loop}), 0);
        chk("rst_flags", int'({step_start, busy, frame_done}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_to_idle", int'(state), 1);

        // 1: full frame, engine answers one cycle after step_start
        eng_en = 1; eng_rnd = 0; eng_delay = 1; eng_cnt = -1;
        build_frame();
        pulse_start();
        chk("t1_enter_conv11", int'(state), 2);
        chk("t1_busy", int'(busy), 1);
        run_frame("t1", 2000);

        // 2: engine delay 5 across a whole frame (covers CONV2_2 ordering)
        eng_delay = 5; eng_cnt = -1;
        build_frame();
        pulse_start();
        run_frame("t2", 4000);

        // 3: spurious step_done in IDLE and in the pending cycle
        eng_en = 0;
        @(negedge clk) step_done = 1'b1;
        @(negedge clk) step_done = 1'b0;
        chk("t3_idle_state", int'(state), 1);
        chk("t3_idle_no_start", int'(step_start), 0);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("t3_pending_start", int'(step_start), 0);
        step_done = 1'b1;
        @(negedge clk) step_done = 1'b0;
        chk("t3_first_start", int'(step_start), 1);
        chk("t3_filter_kept", int'(current_filter), 0);
        @(negedge clk);
        chk("t3_wait", int'(step_start), 0);
        step_done = 1'b1;
        @(negedge clk) step_done = 1'b0;
        chk("t3_filter_inc", int'(current_filter), 1);
        chk("t3_pending2", int'(step_start), 0);
        step_done = 1'b1;
        @(negedge clk) step_done = 1'b0;
        chk("t3_second_start", int'(step_start), 1);
        chk("t3_filter_still1", int'(current_filter), 1);
        @(negedge clk);
        chk("t3_no_extra_start", int'(step_start), 0);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("t3_abort_idle", int'(state), 1);

        // 4: abort coincident with step_done at CONV3_1 (2,7), random engine delays
        eng_en = 1; eng_rnd = 1; eng_cnt = -1;
        exp_q.delete();
        build_frame();
        abort_arm = 1; abort_hit = 0;
        fd_cnt = 0;
        pulse_start();
        i = 0;
        while (!abort_hit && i < 4000) begin
            cycle();
            i++;
        end
        chk("t4_abort_reached", int'(abort_hit), 1);
        eng_en = 0;
        cycle();
        chk("t4_state", int'(state), 1);
        chk("t4_idx", int'({current_loop, current_filter, Pool_loop}), 0);
        chk("t4_flags", int'({step_start, busy, frame_done}), 0);
        chk("t4_no_frame_done", fd_cnt, 0);
        exp_q.delete();
        build_frame();
        eng_en = 1; eng_cnt = -1;
        pulse_start();
        run_frame("t4_restart", 4000);

        // 5: start held through a whole frame
        build_frame();
        start = 1'b1;
        cycle();
        run_frame("t5", 4000);
        eng_en = 0;
        cycle();
        chk("t5_second_frame", int'(state), 2);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("t5_abort_idle", int'(state), 1);
        exp_q.delete();

        // 6: async reset during AVG_POOL2 at Pool_loop=3
        eng_en = 1; eng_rnd = 1; eng_cnt = -1;
        build_frame();
        pulse_start();
        i = 0;
        while (!(state == 4'd7 && Pool_loop == 2'd3) && i < 4000) begin
            cycle();
            i++;
        end
        chk("t6_reached_pool2_3", int'(state == 4'd7 && Pool_loop == 2'd3), 1);
        eng_en = 0;
        step_done = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_state", int'(state), 0);
        chk("t6_async_idx", int'({current_loop, current_filter, Pool_loop}), 0);
        chk("t6_async_flags", int'({step_start, busy, frame_done}), 0);
        @(negedge clk) rst_n = 1'b1;
        chk("t6_held_reset", int'(state), 0);
        @(negedge clk);
        chk("t6_to_idle", int'(state), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
